// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the control unit and the mult/div sequencer.
// MULDIV_ABORT_EN adds the abort request line.
interface muldiv_seq_if;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_b;
    logic        mult_go;
    logic        div_go;
    logic        sel_div;
    logic        hi_write;
    logic        lo_write;
    logic        busy;
    logic        done;
    logic        div_zero;
`ifdef MULDIV_ABORT_EN
    logic        abort;
`endif

    modport master (
`ifdef MULDIV_ABORT_EN
        output abort,
`endif
        output start_mult, start_div, op_b,
        input  mult_go, div_go, sel_div, hi_write, lo_write, busy, done, div_zero
    );

    modport slave (
`ifdef MULDIV_ABORT_EN
        input  abort,
`endif
        input  start_mult, start_div, op_b,
        output mult_go, div_go, sel_div, hi_write, lo_write, busy, done, div_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequences the shared multiplier/divider and strobes HI/LO once the fixed unit latency has elapsed.
// Latency: done N+1 cycles after an accepted start; divide-by-zero done after 1; starts while busy are dropped.
// MULDIV_ABORT_EN: adds an abort input that cancels a running MULT/DIV without writing HI/LO.
module muldiv_seq #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic               clock,
    input  logic               reset,
    muldiv_seq_if.slave        bus
);

    typedef enum logic [2:0] {IDLE, MULT, DIV, WRITE, DZERO} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mult_go_q;
    logic             div_go_q;
    logic             sel_div_q;
    logic             hi_write_q;
    logic             lo_write_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;
    logic             abort_req;

`ifdef MULDIV_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            mult_go_q  <= 1'b0;
            div_go_q   <= 1'b0;
            sel_div_q  <= 1'b0;
            hi_write_q <= 1'b0;
            lo_write_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises only what it owns.
            mult_go_q  <= 1'b0;
            div_go_q   <= 1'b0;
            hi_write_q <= 1'b0;
            lo_write_q <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state)
                IDLE: begin
                    sel_div_q <= 1'b0;
                    busy_q    <= 1'b0;
                    if (bus.start_mult) begin
                        state     <= MULT;
                        cnt       <= CNT_W'(MULT_CYCLES - 1);
                        mult_go_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (bus.start_div) begin
                        if (bus.op_b != 32'd0) begin
                            state     <= DIV;
                            cnt       <= CNT_W'(DIV_CYCLES - 1);
                            div_go_q  <= 1'b1;
                            sel_div_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            state      <= DZERO;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                        end
                    end
                end
                MULT, DIV: begin
                    if (abort_req) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        busy_q    <= 1'b0;
                        sel_div_q <= 1'b0;
                    end else if (cnt == '0) begin
                        state      <= WRITE;
                        hi_write_q <= 1'b1;
                        lo_write_q <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WRITE, DZERO: begin
                    state     <= IDLE;
                    busy_q    <= 1'b0;
                    sel_div_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    busy_q    <= 1'b0;
                    sel_div_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mult_go  = mult_go_q;
    assign bus.div_go   = div_go_q;
    assign bus.sel_div  = sel_div_q;
    assign bus.hi_write = hi_write_q;
    assign bus.lo_write = lo_write_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: table of single operations plus reset/abort sequences.
module tb_muldiv_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    muldiv_seq_if bus();

    muldiv_seq #(.MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sm;
        logic        sd;
        logic [31:0] b;
        int          mid_div;
        int          mid_mult;
        int          lat;
        int          busy_n;
        int          mgo_n;
        int          dgo_n;
        int          sel_n;
        int          wr_n;
        int          done_n;
        int          dz_n;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] outs();
        return {bus.mult_go, bus.div_go, bus.sel_div, bus.hi_write,
                bus.lo_write, bus.busy, bus.done, bus.div_zero};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    int busy_n, mgo_n, dgo_n, sel_n, hw_n, lw_n, done_n, dz_n, lat;

    task automatic clear_counts();
        busy_n = 0; mgo_n = 0; dgo_n = 0; sel_n = 0;
        hw_n = 0; lw_n = 0; done_n = 0; dz_n = 0; lat = -1;
    endtask

    task automatic sample(input int j);
        busy_n += int'(bus.busy);
        mgo_n  += int'(bus.mult_go);
        dgo_n  += int'(bus.div_go);
        sel_n  += int'(bus.sel_div);
        hw_n   += int'(bus.hi_write);
        lw_n   += int'(bus.lo_write);
        done_n += int'(bus.done);
        dz_n   += int'(bus.div_zero);
        if (bus.done && lat < 0) lat = j;
    endtask

    initial begin
        //          sm    sd    op_b          mdiv mmul lat busy mgo dgo sel wr done dz
        vecs[0] = '{1'b1, 1'b0, 32'd5,        0,   0,   33, 32,  1,  0,  0,  1, 1,  0};
        vecs[1] = '{1'b0, 1'b1, 32'd7,        0,   33,  33, 32,  0,  1,  33, 1, 1,  0};
        vecs[2] = '{1'b0, 1'b1, 32'd0,        0,   0,   1,  0,   0,  0,  0,  0, 1,  1};
        vecs[3] = '{1'b1, 1'b1, 32'd3,        10,  33,  33, 32,  1,  0,  0,  1, 1,  0};
        vecs[4] = '{1'b1, 1'b0, 32'd0,        0,   0,   33, 32,  1,  0,  0,  1, 1,  0};
        vecs[5] = '{1'b0, 1'b1, 32'h8000_0000, 0,  5,   33, 32,  0,  1,  33, 1, 1,  0};

        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_b       = 32'd0;
`ifdef MULDIV_ABORT_EN
        bus.abort      = 1'b0;
`endif

        // Reset held for three cycles, then released.
        #1 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_hold_outs", int'(outs()), 0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("post_reset_outs", int'(outs()), 0);
        end

        for (int i = 0; i < 6; i++) begin
            bus.start_mult = vecs[i].sm;
            bus.start_div  = vecs[i].sd;
            bus.op_b       = vecs[i].b;
            clear_counts();
            for (int j = 1; j <= 45; j++) begin
                @(negedge clk);
                bus.start_mult = 1'b0;
                bus.start_div  = 1'b0;
                sample(j);
                if (j == vecs[i].mid_div)  bus.start_div  = 1'b1;
                if (j == vecs[i].mid_mult) bus.start_mult = 1'b1;
            end
            bus.start_mult = 1'b0;
            bus.start_div  = 1'b0;
            check($sformatf("v%0d_latency", i),  lat,    vecs[i].lat);
            check($sformatf("v%0d_busy", i),     busy_n, vecs[i].busy_n);
            check($sformatf("v%0d_mult_go", i),  mgo_n,  vecs[i].mgo_n);
            check($sformatf("v%0d_div_go", i),   dgo_n,  vecs[i].dgo_n);
            check($sformatf("v%0d_sel_div", i),  sel_n,  vecs[i].sel_n);
            check($sformatf("v%0d_hi_write", i), hw_n,   vecs[i].wr_n);
            check($sformatf("v%0d_lo_write", i), lw_n,   vecs[i].wr_n);
            check($sformatf("v%0d_done", i),     done_n, vecs[i].done_n);
            check($sformatf("v%0d_div_zero", i), dz_n,   vecs[i].dz_n);
            @(negedge clk);
            check($sformatf("v%0d_idle_outs", i), int'(outs()), 0);
        end

        // Reset mid-divide while the counter holds 5 (cycle 27 of 32).
        bus.start_div = 1'b1;
        bus.op_b      = 32'd9;
        for (int j = 1; j <= 27; j++) begin
            @(negedge clk);
            bus.start_div = 1'b0;
        end
        check("mid_div_busy", int'(bus.busy), 1);
        check("mid_div_sel", int'(bus.sel_div), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", int'(outs()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            sample(j);
        end
        check("rst_mid_div_done", done_n, 0);
        check("rst_mid_div_write", hw_n + lw_n, 0);
        check("rst_mid_div_busy", busy_n, 0);

`ifdef MULDIV_ABORT_EN
        // Abort sampled mid-multiply drops busy at once and never writes.
        bus.start_mult = 1'b1;
        clear_counts();
        for (int j = 1; j <= 45; j++) begin
            @(negedge clk);
            bus.start_mult = 1'b0;
            bus.abort      = 1'b0;
            sample(j);
            if (j == 11) check("abort_busy_drop", int'(bus.busy), 0);
            if (j == 10) bus.abort = 1'b1;
        end
        check("abort_done", done_n, 0);
        check("abort_write", hw_n + lw_n, 0);
        check("abort_busy_cycles", busy_n, 10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
